// File: rtl/mux4_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux4_arb_pkg
// Shared definitions for the 4:1 mux round-robin arbiter:
//   - arbiter FSM state encoding
//   - requester count and select width
//   - one-hot decode helper for the grant vector
// -----------------------------------------------------------------------------
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SWITCH = 2'd2
  } arb_state_e;

  // Decode a requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// -----------------------------------------------------------------------------
// mux4_rr_pick
// Combinational rotate-priority encoder. The search starts at last+1 (mod 4)
// and wraps, so the previous owner has the lowest priority.
// Ports:
//   req   [3:0] in  : request vector
//   last  [1:0] in  : index of the most recent owner
//   found       out : at least one request is set
//   idx   [1:0] out : winning requester (equals last when nothing is found)
// -----------------------------------------------------------------------------
module mux4_rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // NOTE: every signal written in a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + SEL_W'(k);  // wraps naturally in 2 bits
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter and select sequencer for a shared 4:1 single-bit mux.
// Grants one requester at a time, bounds each tenure to HOLD_CYCLES while
// others wait, inserts a one-cycle dead slot between owners, and registers
// the selected data bit with a valid qualifier.
//
// Parameters:
//   HOLD_CYCLES : max consecutive GRANT cycles under contention (1..255)
// Ports:
//   clk         in  : rising-edge clock
//   rst_n       in  : asynchronous active-low reset
//   req   [3:0] in  : level-held request per requester
//   d     [3:0] in  : data bit per requester
//   lock        in  : tenure extension (only with MUX4_ARB_LOCK_EN)
//   gnt   [3:0] out : one-hot registered grant
//   s1, s0      out : registered select pair (owner index)
//   y           out : registered mux output
//   y_vld       out : y carries the granted requester's data
//
// Build option: define MUX4_ARB_LOCK_EN to add the lock port. While the owner
// requests with lock high, the hold limit is ignored and hold_cnt freezes.
// -----------------------------------------------------------------------------
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] d,
`ifdef MUX4_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic               s1,
  output logic               s0,
  output logic               y,
  output logic               y_vld
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;     // current / most recent owner
  logic [SEL_W-1:0]   last_q, last_d;   // round-robin pointer
  logic [7:0]         cnt_q, cnt_d;     // cycles spent in this tenure
  logic [NUM_REQ-1:0] gnt_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               others_req;
  logic               lock_hold;

  mux4_rr_pick u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign others_req = |(req & ~sel_onehot(sel_q));

`ifdef MUX4_ARB_LOCK_EN
  assign lock_hold = lock & req[sel_q];
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt;
    unique case (state_q)
      ST_IDLE, ST_SWITCH: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          gnt_d   = sel_onehot(pick_idx);
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (!req[sel_q]) begin
          // An owner drop wins over a simultaneous hold-limit hit.
          state_d = others_req ? ST_SWITCH : ST_IDLE;
          gnt_d   = '0;
        end else if (lock_hold) begin
          // Locked tenure: limit ignored, counter frozen.
        end else if (cnt_q == HOLD_LAST) begin
          if (others_req) begin
            state_d = ST_SWITCH;
            gnt_d   = '0;
          end
          // No contender: stay with the counter saturated.
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      gnt     <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
    end
  end

  // Data path: y follows the owner's bit one cycle behind the grant and holds
  // its last value outside GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= 1'b0;
      y_vld <= 1'b0;
    end else begin
      y_vld <= (state_q == ST_GRANT);
      if (state_q == ST_GRANT) begin
        y <= d[sel_q];
      end
    end
  end

  assign s1 = sel_q[1];
  assign s0 = sel_q[0];

endmodule
